// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default stability window for the debouncer
package debounce_pkg;
    typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
    localparam int DEBOUNCE_10MS = 1000000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one channel of synchroniser, debounce FSM, stability counter and registered outputs
// ports: clk, rst (sync, active-high), raw_in (async pin), clean_out (debounced level),
//        rise_pulse / fall_pulse (one-cycle edge strobes of clean_out)
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_10MS,
    parameter int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic s1_q, s1_d, s2_q, s2_d;
    logic clean_q, clean_d, rise_q, rise_d, fall_q, fall_d;
    always_comb begin
        s1_d = raw_in;
        s2_d = s1_q;
        state_d = state_q;
        cnt_d = cnt_q;
        clean_d = clean_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        case (state_q)
            IDLE_LOW: if (s2_q) begin
                state_d = WAIT_HIGH;
                cnt_d = CNT_W'(1);
            end
            WAIT_HIGH: if (!s2_q) begin
                state_d = IDLE_LOW;
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                state_d = IDLE_HIGH;
                clean_d = 1'b1;
                rise_d = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            IDLE_HIGH: if (!s2_q) begin
                state_d = WAIT_LOW;
                cnt_d = CNT_W'(1);
            end
            WAIT_LOW: if (s2_q) begin
                state_d = IDLE_HIGH;
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                state_d = IDLE_LOW;
                clean_d = 1'b0;
                fall_d = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            state_q <= IDLE_LOW;
            cnt_q <= '0;
            clean_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            clean_q <= clean_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
    assign clean_out = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: N_CH independent synchronise-and-debounce channels
// ports: clk, rst (sync, active-high), raw_in[N_CH] (async pins),
//        clean_out / rise_pulse / fall_pulse [N_CH] (registered per-channel outputs)
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int STABLE_CYCLES = DEBOUNCE_10MS,
    parameter int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
);
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_ch (
            .clk(clk),
            .rst(rst),
            .raw_in(raw_in[g]),
            .clean_out(clean_out[g]),
            .rise_pulse(rise_pulse[g]),
            .fall_pulse(fall_pulse[g])
        );
    end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: table, hand-written corner sequences and random stimulus against a run-length model
module tb_input_debouncer;
    localparam int S = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] raw_in = 2'b00;
    logic [1:0] clean_out, rise_pulse, fall_pulse;
    int errors = 0;
    int checks = 0;
    logic [1:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_rise = '0, m_fall = '0;
    int run [2];
    typedef struct packed {
        logic r;
        logic [1:0] raw;
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;
    vec_t tbl [11];

    input_debouncer #(.N_CH(2), .STABLE_CYCLES(S)) dut (
        .clk(clk),
        .rst(rst),
        .raw_in(raw_in),
        .clean_out(clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    // A level is accepted once STABLE consecutive synchronised samples disagree with it.
    task automatic model_edge();
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
            run[0] = 0; run[1] = 0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < 2; c++) begin
                run[c] = (m_s2[c] != m_clean[c]) ? run[c] + 1 : 0;
                if (run[c] == S) begin
                    m_clean[c] = ~m_clean[c];
                    if (m_clean[c]) m_rise[c] = 1'b1;
                    else m_fall[c] = 1'b1;
                    run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw_in;
        end
    endtask

    task automatic step(input logic r, input logic [1:0] raw);
        rst = r;
        raw_in = raw;
        @(posedge clk);
        model_edge();
        #1;
        chk("model", {clean_out, rise_pulse, fall_pulse}, {m_clean, m_rise, m_fall});
    endtask

    task automatic settle(input logic [1:0] raw);
        for (int i = 0; i < 8; i++) step(1'b0, raw);
    endtask

    initial begin
        logic [1:0] pat [4];
        logic [1:0] rr;
        tbl[0]  = {1'b1, 2'b11, 2'b00, 2'b00, 2'b00};
        tbl[1]  = {1'b1, 2'b11, 2'b00, 2'b00, 2'b00};
        tbl[2]  = {1'b1, 2'b11, 2'b00, 2'b00, 2'b00};
        tbl[3]  = {1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        tbl[4]  = {1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        tbl[5]  = {1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        tbl[6]  = {1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        tbl[7]  = {1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        tbl[8]  = {1'b0, 2'b11, 2'b11, 2'b11, 2'b00};
        tbl[9]  = {1'b0, 2'b11, 2'b11, 2'b00, 2'b00};
        tbl[10] = {1'b0, 2'b11, 2'b11, 2'b00, 2'b00};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].r, tbl[i].raw);
            chk($sformatf("reset_tbl[%0d]", i), {clean_out, rise_pulse, fall_pulse},
                {tbl[i].clean, tbl[i].rise, tbl[i].fall});
        end

        settle(2'b10);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 2'b11);
            chk($sformatf("clean_rise[%0d]", i), {clean_out, rise_pulse, fall_pulse},
                i == 5 ? 6'b11_01_00 : (i < 5 ? 6'b10_00_00 : 6'b11_00_00));
        end

        settle(2'b10);
        pat = '{2'b11, 2'b11, 2'b10, 2'b10};
        for (int i = 0; i < 14; i++) begin
            step(1'b0, i < 8 ? pat[i % 4] : 2'b10);
            chk($sformatf("bounce[%0d]", i), {3'b0, clean_out[0], rise_pulse[0], fall_pulse[0]}, 6'b0);
        end

        settle(2'b10);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i == 2 ? 2'b10 : 2'b11);
            chk($sformatf("bounce_settle[%0d]", i), {3'b0, clean_out[0], rise_pulse[0], fall_pulse[0]},
                i == 8 ? 6'b110 : (i == 9 ? 6'b100 : 6'b000));
        end

        settle(2'b10);
        for (int i = 0; i < 11; i++) begin
            step(i == 3, 2'b11);
            chk($sformatf("reset_mid_wait[%0d]", i), {3'b0, clean_out[0], rise_pulse[0], fall_pulse[0]},
                i == 9 ? 6'b110 : (i == 10 ? 6'b100 : 6'b000));
        end

        settle(2'b01);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 2'b10);
            chk($sformatf("indep[%0d]", i), {clean_out, rise_pulse, fall_pulse},
                i == 5 ? 6'b10_10_01 : (i < 5 ? 6'b01_00_00 : 6'b10_00_00));
        end

        rr = 2'b00;
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < 2; c++) if ($urandom_range(0, 3) == 0) rr[c] = ~rr[c];
            step($urandom_range(0, 79) == 0, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/input_debouncer.md
# input_debouncer

Multi-channel input conditioner that sits directly upstream of the up/down counter and clock-divider stages. It takes raw, asynchronous board inputs (push buttons, slide switches), synchronises them into the 100 MHz `clk` domain, and rejects bounce. Each channel produces a clean level and single-cycle rise/fall pulses. The counter's direction switch and any step/reset buttons consume these clean signals instead of raw pins.

## Interface

Parameters:
- `N_CH`, default 2: number of independent input channels.
- `STABLE_CYCLES`, default 1000000: consecutive stable synchronised samples required to accept a level change (10 ms at 100 MHz). Legal range is 2 or more.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: stability counter width. Derived; not overridden.

Ports:
- `clk`, input, 1: 100 MHz board clock. The only clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `raw_in`, input, `N_CH`: asynchronous raw pin levels.
- `clean_out`, output, `N_CH`: debounced level per channel.
- `rise_pulse`, output, `N_CH`: one-`clk` pulse when `clean_out` goes 0→1.
- `fall_pulse`, output, `N_CH`: one-`clk` pulse when `clean_out` goes 1→0.

## Operation

- **Per channel:** a 2-flop synchroniser (`s1`, `s2`) feeds a 4-state FSM and a `CNT_W`-bit stability counter. Channels are fully independent.
- **States:**
  - `IDLE_LOW`: `clean_out`=0.
  - `WAIT_HIGH`: `clean_out`=0, candidate 1.
  - `IDLE_HIGH`: `clean_out`=1.
  - `WAIT_LOW`: `clean_out`=1, candidate 0.
- **Transitions:**
  - `IDLE_LOW`, `s2`=1 → `WAIT_HIGH`, cnt←1.
  - `WAIT_HIGH`, `s2`=0 → `IDLE_LOW`, cnt←0. This is a bounce: no output change.
  - `WAIT_HIGH`, `s2`=1 and cnt=`STABLE_CYCLES`-1 → `IDLE_HIGH`, `clean_out`←1, `rise_pulse`←1, cnt←0.
  - `WAIT_HIGH`, `s2`=1 otherwise → cnt←cnt+1.
  - `IDLE_HIGH`, `WAIT_LOW`: mirror image of the above, with `fall_pulse`.
- **Outputs:** `clean_out`, `rise_pulse` and `fall_pulse` are registered. Each pulse is high for exactly one cycle. `rise_pulse` and `fall_pulse` are never both high on the same channel.
- **Counter:** never exceeds `STABLE_CYCLES`-1 and never wraps. It is zero in both IDLE states.
- **Reset:** while `rst`=1 at a `clk` edge, every channel gets `s1`=`s2`=0, state `IDLE_LOW`, cnt=0, `clean_out`=0, and both pulses 0. Reset takes priority over all transitions, so a reset during WAIT aborts the pending change.
- **Input high through reset release:** the channel accepts a 1 after the normal latency and emits one `rise_pulse`.

## Timing

- Let raw change before edge k, then stay constant:
  - `s2` carries the new value after edge k+1.
  - The FSM enters WAIT at edge k+2.
  - `clean_out` and the pulse update at edge k+1+`STABLE_CYCLES`.
- Latency: raw change to `clean_out` change is `STABLE_CYCLES`+2 edges.
- Any return of `s2` to the old level before acceptance restarts the full `STABLE_CYCLES` window on the next change.
- Minimum accepted pulse width: a raw level must hold for `STABLE_CYCLES` consecutive synchronised samples. Anything shorter produces no output activity.
- No combinational path from `raw_in` to any output.

## Structure

- **Shared package `debounce_pkg`:**
  - State enum: `IDLE_LOW`, `WAIT_HIGH`, `IDLE_HIGH`, `WAIT_LOW`, 2-bit encoding.
  - Default constant `DEBOUNCE_10MS` = 1000000.
- **Sub-module `debounce_channel`:** one channel, covering the synchroniser, FSM, counter and output registers. `input_debouncer` instantiates `N_CH` copies in a generate loop.

## Test plan

Bench uses `STABLE_CYCLES`=4 and `N_CH`=2.

1. **Reset values:** hold `rst` for 3 cycles with `raw_in`=2'b11. Every output is 0 during reset. After release, `clean_out`=2'b11 exactly 6 edges later, with a single-cycle `rise_pulse`=2'b11.
2. **Clean rise:** ch0 goes 0→1 before edge k. `clean_out[0]` goes high at edge k+5, `rise_pulse[0]` is high for one cycle only, and ch1 does not change.
3. **Bounce rejection:** ch0 toggles 1,0,1,0 every 2 cycles, then stays 0. `clean_out[0]` stays 0 and no pulses occur.
4. **Bounce then settle:** ch0 gives 1 for 2 cycles, 0 for 1, then 1 steady. Acceptance occurs `STABLE_CYCLES`+2 edges after the final 0→1, not after the first.
5. **Reset mid-wait:** ch0 rises, and `rst` is pulsed at edge k+3. No `rise_pulse` at k+5. `clean_out[0]` goes to 1 exactly 6 edges after reset release.
6. **Independent channels:** ch0 falls and ch1 rises on the same cycle. `fall_pulse[0]` and `rise_pulse[1]` assert on the same edge, with no cross-channel pulses.
